// File: rtl/round_key_sequencer.sv
// Registers an expanded AES key schedule and streams one 128-bit round key per handshake.
// Optional ROUND_KEY_ZEROIZE_EN clears the schedule after each completed or aborted stream.
module round_key_sequencer #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [0:128*(Nr+1)-1]  keys,
    input  logic                   load,
    input  logic                   start,
    input  logic                   dir,
    input  logic                   abort,
    output logic                   rk_valid,
    input  logic                   rk_ready,
    output logic [0:127]           rk_data,
    output logic [3:0]             rk_round,
    output logic                   rk_last,
    output logic                   sched_valid,
    output logic                   busy,
    output logic                   done
);
    localparam int         SchedW    = 128 * (Nr + 1);
    localparam logic [3:0] LastRound = 4'(Nr);

    typedef enum logic [1:0] {EMPTY, LOADED, STREAM} stateT;

`ifdef ROUND_KEY_ZEROIZE_EN
    localparam stateT EndState = EMPTY;
`else
    localparam stateT EndState = LOADED;
`endif

    stateT             state;
    stateT             nextState;
    logic [0:SchedW-1] sched;
    logic [0:127]      schedWords [0:Nr];
    logic [3:0]        roundIdx;
    logic              dirReg;
    logic              lastKey;
    logic              xfer;
    logic              capture;
    logic              launch;
    logic              finish;

    for (genvar i = 0; i <= Nr; i++) begin : gWords
        assign schedWords[i] = sched[128*i +: 128];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    // abort outranks a transfer presented in the same cycle
    always_comb begin
        xfer    = rk_valid && rk_ready;
        capture = load && (state != STREAM);
        launch  = (state == LOADED) && !load && start;
        finish  = (state == STREAM) && !abort && xfer && lastKey;
    end

    always_comb begin
        nextState = state;
        case (state)
            EMPTY:   if (load) nextState = LOADED;
            LOADED:  if (load) nextState = LOADED;
                     else if (start) nextState = STREAM;
            STREAM:  if (abort || finish) nextState = EndState;
            default: nextState = EMPTY;
        endcase
    end

    always_comb begin
        rk_valid    = (state == STREAM);
        busy        = (state == STREAM);
        sched_valid = (state != EMPTY);
        lastKey     = dirReg ? (roundIdx == 4'd0) : (roundIdx == LastRound);
        rk_last     = rk_valid && lastKey;
        rk_round    = roundIdx;
        rk_data     = rk_valid ? schedWords[roundIdx] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sched    <= '0;
            roundIdx <= '0;
            dirReg   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (capture) begin
                sched <= keys;
            end
`ifdef ROUND_KEY_ZEROIZE_EN
            else if ((state == STREAM) && (abort || finish)) begin
                sched <= '0;
            end
`endif
            if (launch) begin
                dirReg   <= dir;
                roundIdx <= dir ? LastRound : 4'd0;
            end else if ((state == STREAM) && !abort && xfer && !lastKey) begin
                roundIdx <= dirReg ? roundIdx - 4'd1 : roundIdx + 4'd1;
            end
        end
    end
endmodule

// File: doc/round_key_sequencer.md
Name: round_key_sequencer

Overview:
Sits directly downstream of the combinational key schedule generator. It registers the full expanded schedule bus, then streams one 128-bit round key per handshake to an iterative round engine. Encrypt order is round 0..Nr; decrypt order is Nr..0. This decouples the long combinational expansion path from the round datapath.

Parameters:
Nk, 4, key length in 32-bit words (4/6/8 for AES-128/192/256)
Nr, Nk+6, number of rounds; the schedule holds Nr+1 round keys

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
keys  input  128*(Nr+1)  expanded schedule, [0:...] big-endian; round 0 key in keys[0:127]
load  input  1  capture keys into the internal schedule register
start  input  1  begin streaming
dir  input  1  sampled with start: 0 = encrypt (ascending), 1 = decrypt (descending)
abort  input  1  terminate an active stream
rk_valid  output  1  rk_data is valid
rk_ready  input  1  consumer accepts rk_data
rk_data  output  128  current round key, [0:127]
rk_round  output  4  index of the current round key, 0..Nr
rk_last  output  1  high with the final key of the stream (round Nr enc, round 0 dec)
sched_valid  output  1  schedule register holds a loaded key set
busy  output  1  state == STREAM
done  output  1  one-cycle pulse after the last key handshake

Behaviour:
- Reset (rst_n=0, async): state=EMPTY, schedule register=0, sched_valid=0, rk_valid=0, rk_data=0, rk_round=0, rk_last=0, busy=0, done=0.
- States: EMPTY (no schedule), LOADED (schedule held, idle), STREAM (emitting keys).
- load in EMPTY or LOADED: keys are registered at that edge; sched_valid=1 the next cycle; state=LOADED.
- load in STREAM: ignored. The schedule stays stable for the whole stream.
- start in EMPTY: ignored.
- start in LOADED (load=0): latch dir and go to STREAM.
  - Next cycle: rk_valid=1, rk_round=0 (dir=0) or Nr (dir=1), rk_data = schedule slice [128*rk_round +: 128].
- load and start in the same LOADED cycle: load wins, start is ignored.
- Handshake: a transfer occurs when rk_valid & rk_ready.
  - rk_data, rk_round and rk_last hold stable while rk_valid & !rk_ready.
  - On a transfer that is not last, rk_round increments (enc) or decrements (dec) at that edge. Back-to-back transfers give one key per cycle.
- Last transfer (rk_last & rk_ready):
  - Next cycle: rk_valid=0, state=LOADED, done=1 for exactly one cycle.
  - start may be accepted on the cycle done is high.
- abort in STREAM: next cycle rk_valid=0, state=LOADED, done stays 0. abort has priority over a simultaneous transfer. abort outside STREAM has no effect.
- rk_last is combinational from rk_round and the latched dir, qualified by rk_valid.
- rk_round never leaves 0..Nr; there is no wrap-around.
- Latency: start to first rk_valid is 1 cycle. load to sched_valid is 1 cycle.

Optional Feature:
Macro: ROUND_KEY_ZEROIZE_EN.
- Defined: on the last transfer or on abort, the schedule register is cleared to 0 and sched_valid=0 (state=EMPTY instead of LOADED). A new load is required before the next start; rk_data reads 0 whenever rk_valid=0.
- Undefined: the schedule is retained for repeated streams, and rk_data is don't-care while rk_valid=0.

Test Plan:
- Nk=4, keys from key 000102030405060708090a0b0c0d0e0f; load; start dir=0; rk_ready=1 → 11 keys in 11 consecutive cycles. Round0=000102030405060708090a0b0c0d0e0f, round1=d6aa74fdd2af72fadaa678f1d6aa74fd, round10=13111d7fe3944a17f307a78b4d2b30c5 with rk_last=1; done pulses 1 cycle later.
- Same schedule, start dir=1 → first key 13111d7f..., rk_round=10; final key 00010203... with rk_round=0 and rk_last=1.
- rk_ready toggled 1,0,0,1 during streaming → rk_data/rk_round hold during stalls; no key is skipped or duplicated; 11 transfers total.
- load asserted during STREAM with a different keys value → stream continues with the original schedule; start and load in the same LOADED cycle → no stream starts and the new schedule is captured.
- abort after the round-3 transfer → rk_valid=0 the next cycle, done=0, busy=0. A restart begins again at round 0 (no zeroize) or is ignored until reload (ROUND_KEY_ZEROIZE_EN).
- rst_n pulled low mid-stream at round 5 → all outputs 0 immediately; start before a new load is ignored.
